// File: rtl/i2s_codec_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_pkg
//  Description : Shared sample type and slot-window helpers for the I2S codec
//                interface.  The data window inside each channel slot is bit
//                positions c_winFirst..c_winLast (one bclk after the lrclk edge,
//                MSB first).
//  Revision    : 1.0  initial release
// ============================================================================
package codec_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Bit positions within a slot that carry sample data.
    localparam int c_winFirst = 1;
    localparam int c_winLast  = SAMPLE_W;

    // True when a bit position within a slot lies in the data window.
    function automatic logic inWindow(input int pos);
        return (pos >= c_winFirst) && (pos <= c_winLast);
    endfunction

endpackage : codec_pkg
`default_nettype wire

// File: rtl/i2s_codec_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_codec_if_if
//  Description : Bundle of the codec serial pins and the sample-side bus.
//                master : the I2S interface block (drives bclk, lrclk,
//                         dac_data, SampleIn, ready; reads adc_data, SampleOut)
//                slave  : codec + pitch-shift core side (reverse directions)
//  Revision    : 1.0  initial release
// ============================================================================
interface i2s_codec_if_if;
    import codec_pkg::*;

    logic    bclk;
    logic    lrclk;
    logic    adc_data;
    logic    dac_data;
    sample_t SampleOut;
    sample_t SampleIn;
    logic    ready;

    modport master (
        output bclk, lrclk, dac_data, SampleIn, ready,
        input  adc_data, SampleOut
    );

    modport slave (
        input  bclk, lrclk, dac_data, SampleIn, ready,
        output adc_data, SampleOut
    );

endinterface : i2s_codec_if_if
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_clk_gen
//  Description : Bit-clock and word-select generator.  div_cnt runs
//                0..BCLK_DIV-1; bclk toggles at terminal count.  bit_idx
//                advances on each bclk falling strobe and wraps every
//                2*SLOT_BITS bits; lrclk follows bit_idx >= SLOT_BITS.
//  Ports       : clk, reset          clock, async active-high reset
//                o_bclk, o_lrclk     registered codec clocks
//                o_riseStb/o_fallStb one-clk strobes, high in the cycle
//                                    before bclk rises / falls
//                o_bitIdx            current bit index in the frame
//                o_bitIdxNext        index that becomes current on fall
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_clk_gen #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32,
    parameter int IDX_W     = $clog2(2 * SLOT_BITS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    output logic                  o_bclk,
    output logic                  o_lrclk,
    output logic                  o_riseStb,
    output logic                  o_fallStb,
    output logic [IDX_W-1:0]      o_bitIdx,
    output logic [IDX_W-1:0]      o_bitIdxNext
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] c_divLast  = DIV_W'(BCLK_DIV - 1);
    localparam logic [IDX_W-1:0] c_idxLast  = IDX_W'(2 * SLOT_BITS - 1);
    localparam logic [IDX_W-1:0] c_slotBits = IDX_W'(SLOT_BITS);

    logic [DIV_W-1:0] r_divCnt;
    logic             r_bclk;
    logic             r_lrclk;
    logic [IDX_W-1:0] r_bitIdx;
    logic             w_tc;
    logic [IDX_W-1:0] w_bitIdxNext;

    assign w_tc         = (r_divCnt == c_divLast);
    assign w_bitIdxNext = (r_bitIdx == c_idxLast) ? '0 : r_bitIdx + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divCnt <= '0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_bitIdx <= '0;
        end else if (w_tc) begin
            r_divCnt <= '0;
            r_bclk   <= ~r_bclk;
            // Falling edge of bclk: move to the next bit of the frame.
            if (r_bclk) begin
                r_bitIdx <= w_bitIdxNext;
                r_lrclk  <= (w_bitIdxNext >= c_slotBits);
            end
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    assign o_bclk       = r_bclk;
    assign o_lrclk      = r_lrclk;
    assign o_riseStb    = w_tc & ~r_bclk;
    assign o_fallStb    = w_tc & r_bclk;
    assign o_bitIdx     = r_bitIdx;
    assign o_bitIdxNext = w_bitIdxNext;

endmodule : i2s_clk_gen
`default_nettype wire

// File: rtl/i2s_codec_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_codec_if
//  Description : Master-mode I2S interface to the stereo codec.  Receives the
//                ADC stream into SampleIn (one ready pulse per frame) and
//                transmits SampleOut on both DAC channels.
//                Optional build macro MONO_MIX_EN: SampleIn = (L + R) >>> 1
//                instead of the left word.
//  Ports       : clk, reset  clock, async active-high reset
//                bus         i2s_codec_if_if.master: bclk, lrclk, dac_data,
//                            SampleIn, ready out; adc_data, SampleOut in
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_codec_if
    import codec_pkg::*;
#(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    i2s_codec_if_if.master  bus
);

    localparam int IDX_W = $clog2(2 * SLOT_BITS);
    localparam int SEL_W = $clog2(SAMPLE_W);
    localparam logic [IDX_W-1:0] c_slotBits  = IDX_W'(SLOT_BITS);
    localparam logic [IDX_W-1:0] c_leftLast  = IDX_W'(c_winLast);
    localparam logic [IDX_W-1:0] c_rightLast = IDX_W'(SLOT_BITS + c_winLast);

    logic             w_bclk;
    logic             w_lrclk;
    logic             w_riseStb;
    logic             w_fallStb;
    logic [IDX_W-1:0] w_bitIdx;
    logic [IDX_W-1:0] w_bitIdxNext;

    i2s_clk_gen #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS),
        .IDX_W     (IDX_W)
    ) u_clkGen (
        .clk          (clk),
        .reset        (reset),
        .o_bclk       (w_bclk),
        .o_lrclk      (w_lrclk),
        .o_riseStb    (w_riseStb),
        .o_fallStb    (w_fallStb),
        .o_bitIdx     (w_bitIdx),
        .o_bitIdxNext (w_bitIdxNext)
    );

    logic                  r_sync1;
    logic                  r_sync2;
    logic [SAMPLE_W-2:0]   r_shift;   // last SAMPLE_W-1 received bits
    sample_t               r_left;
    sample_t               r_txHold;
    sample_t               r_sampleIn;
    logic                  r_dac;
    logic                  r_ready;

    sample_t               w_shiftNext;
    sample_t               w_rxWord;
    logic [IDX_W-1:0]      w_txPos;
    logic [SEL_W-1:0]      w_txSel;
    logic                  w_dacNext;

    // Word including the bit being shifted in on this rise strobe, so the
    // last bit of a slot is available in the same cycle it arrives.
    assign w_shiftNext = {r_shift, r_sync2};

`ifdef MONO_MIX_EN
    logic signed [SAMPLE_W:0] w_sum;
    // Sign-extend both words so the sum cannot overflow before halving.
    assign w_sum    = {r_left[SAMPLE_W-1], r_left} + {w_shiftNext[SAMPLE_W-1], w_shiftNext};
    assign w_rxWord = SAMPLE_W'(w_sum >>> 1);
`else
    assign w_rxWord = r_left;
`endif

    // DAC bit for the index entered on the coming bclk fall.
    always_comb begin
        w_txPos   = (w_bitIdxNext >= c_slotBits) ? w_bitIdxNext - c_slotBits : w_bitIdxNext;
        w_txSel   = SEL_W'(IDX_W'(SAMPLE_W) - w_txPos);
        w_dacNext = inWindow(int'(w_txPos)) ? r_txHold[w_txSel] : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_shift    <= '0;
            r_left     <= '0;
            r_txHold   <= '0;
            r_sampleIn <= '0;
            r_dac      <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_sync1 <= bus.adc_data;
            r_sync2 <= r_sync1;
            r_ready <= 1'b0;

            if (w_riseStb) begin
                r_shift <= w_shiftNext[SAMPLE_W-2:0];
                if (w_bitIdx == c_leftLast) begin
                    r_left <= w_shiftNext;
                end
                if (w_bitIdx == c_rightLast) begin
                    r_sampleIn <= w_rxWord;
                    r_ready    <= 1'b1;
                end
            end

            if (w_fallStb) begin
                r_dac <= w_dacNext;
                // Frame boundary: take a fresh sample for the whole frame.
                if (w_bitIdxNext == '0) begin
                    r_txHold <= bus.SampleOut;
                end
            end
        end
    end

    assign bus.bclk     = w_bclk;
    assign bus.lrclk    = w_lrclk;
    assign bus.dac_data = r_dac;
    assign bus.SampleIn = r_sampleIn;
    assign bus.ready    = r_ready;

endmodule : i2s_codec_if
`default_nettype wire
